// File: rtl/display_scan_controller.sv
// Multiplexed-display scan engine: rotates through the enabled digits at a fixed
// slot rate and gates each digit's anode with global blanking and PWM brightness.
module display_scan_controller #(
    parameter int NUM_DIGITS       = 8,
    parameter int SCAN_DIV         = 50000,
    parameter int PWM_BITS         = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int SEL_W           = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  blank,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [SEL_W-1:0]      seg_sel,
    output logic                  slot_tick
);

    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int ON_STEP = SCAN_DIV / (2 ** PWM_BITS);
    localparam logic [PWM_BITS-1:0]   BRIGHT_FULL = '1;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [SEL_W-1:0]      seg_sel_q;
    logic                  slot_tick_q;

    logic                  boundary;
    logic                  on_time;
    logic                  lit;
    logic [31:0]           on_limit;
    logic                  found;
    logic [SEL_W-1:0]      cand;
    int                    cand_sum;

    assign boundary = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);

    // Full brightness bypasses the compare so truncation in ON_STEP never dims it.
    assign on_limit = 32'(brightness) * 32'(ON_STEP);
    assign on_time  = (brightness == BRIGHT_FULL) || (32'(cnt_q) < on_limit);
    assign lit      = !blank && digit_en[idx_q] && on_time;

    // Search idx+1 .. idx+NUM_DIGITS; the last candidate is idx itself, and an
    // all-zero enable mask leaves idx unchanged.
    always_comb begin
        idx_d    = idx_q;
        found    = 1'b0;
        cand     = '0;
        cand_sum = 0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand_sum = int'(idx_q) + k;
            if (cand_sum >= NUM_DIGITS) begin
                cand_sum = cand_sum - NUM_DIGITS;
            end
            cand = SEL_W'(cand_sum);
            if (!found && digit_en[cand]) begin
                idx_d = cand;
                found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign anodes_d[gi] = (lit && (idx_q == SEL_W'(gi))) ? ~ANODES_OFF[gi]
                                                                 : ANODES_OFF[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            anodes_q    <= ANODES_OFF;
            seg_sel_q   <= '0;
            slot_tick_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            if (boundary) begin
                idx_q <= idx_d;
            end
            anodes_q    <= anodes_d;
            seg_sel_q   <= idx_q;
            slot_tick_q <= boundary;
        end
    end

    assign anodes    = anodes_q;
    assign seg_sel   = seg_sel_q;
    assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised and directed bench for display_scan_controller against a cycle-level
// reference model built from the scan, PWM and blanking rules.
module tb_display_scan_controller;

    localparam int ND   = 4;
    localparam int DIV  = 16;
    localparam int PWMB = 2;
    localparam int STEP = DIV / (1 << PWMB);
    localparam int FULL = (1 << PWMB) - 1;

    logic          clk;
    logic          reset;
    logic [ND-1:0] digit_en;
    logic [PWMB-1:0] brightness;
    logic          blank;
    logic [ND-1:0] anodes;
    logic [1:0]    seg_sel;
    logic          slot_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int            m_cnt;
    int            m_idx;
    logic [ND-1:0] exp_anodes;
    logic [1:0]    exp_sel;
    logic          exp_tick;

    display_scan_controller #(
        .NUM_DIGITS(ND),
        .SCAN_DIV(DIV),
        .PWM_BITS(PWMB),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digit_en(digit_en),
        .brightness(brightness),
        .blank(blank),
        .anodes(anodes),
        .seg_sel(seg_sel),
        .slot_tick(slot_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First enabled digit strictly after cur in rotation order; cur itself last.
    function automatic int next_enabled(input int cur, input logic [ND-1:0] en);
        int order[$];
        for (int k = 1; k <= ND; k++) order.push_back((cur + k) % ND);
        foreach (order[i]) begin
            if (en[order[i]]) return order[i];
        end
        return cur;
    endfunction

    // Advance the model by one clock with the inputs as currently driven, clock the
    // DUT, then compare all outputs on the falling edge.
    task automatic step(input string tag);
        logic lit;
        if (reset) begin
            m_cnt      = 0;
            m_idx      = 0;
            exp_anodes = '1;
            exp_sel    = '0;
            exp_tick   = 1'b0;
        end else begin
            lit = !blank && digit_en[m_idx] &&
                  ((int'(brightness) == FULL) || (m_cnt < int'(brightness) * STEP));
            exp_anodes = lit ? ~(4'b0001 << m_idx) : 4'b1111;
            exp_sel    = 2'(m_idx);
            exp_tick   = (m_cnt == DIV - 1);
            if (m_cnt == DIV - 1) m_idx = next_enabled(m_idx, digit_en);
            m_cnt = (m_cnt + 1) % DIV;
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (anodes !== exp_anodes) begin
            n_bad++;
            $display("FAIL %s anodes: got %b expected %b (t=%0t)", tag, anodes, exp_anodes, $time);
        end
        n_cmp++;
        if (seg_sel !== exp_sel) begin
            n_bad++;
            $display("FAIL %s seg_sel: got %0d expected %0d (t=%0t)", tag, seg_sel, exp_sel, $time);
        end
        n_cmp++;
        if (slot_tick !== exp_tick) begin
            n_bad++;
            $display("FAIL %s slot_tick: got %b expected %b (t=%0t)", tag, slot_tick, exp_tick, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("reset");
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        digit_en   = 4'($urandom);
        brightness = 2'($urandom);
        blank      = 1'($urandom);
        step("reset_a");
        step("reset_b");
        n_cmp++;
        if (anodes !== 4'b1111 || seg_sel !== 2'd0 || slot_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_const: got %b/%0d/%b expected 1111/0/0", anodes, seg_sel, slot_tick);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_full_scan();
        int ticks;
        digit_en = 4'b1111; brightness = 2'd3; blank = 1'b0;
        do_reset();
        ticks = 0;
        for (int i = 0; i < 5 * DIV; i++) begin
            step("full_scan");
            if (slot_tick === 1'b1) ticks++;
            // seg_sel settles to digit 1 two cycles after the first boundary
            if (i == DIV + 1) begin
                n_cmp++;
                if (seg_sel !== 2'd1 || anodes !== 4'b1101) begin
                    n_bad++;
                    $display("FAIL full_scan_slot1: got %0d/%b expected 1/1101", seg_sel, anodes);
                end
            end
        end
        n_cmp++;
        if (ticks != 5) begin
            n_bad++;
            $display("FAIL full_scan_ticks: got %0d expected 5", ticks);
        end
        $display("test_full_scan done");
    endtask

    task automatic test_brightness();
        int on_cycles;
        digit_en = 4'b1111; blank = 1'b0;
        for (int b = 0; b < 3; b++) begin
            brightness = 2'(b);
            on_cycles  = 0;
            for (int i = 0; i < 2 * DIV; i++) begin
                step("brightness");
                if (anodes !== 4'b1111) on_cycles++;
            end
            n_cmp++;
            if (on_cycles != 2 * b * STEP) begin
                n_bad++;
                $display("FAIL brightness_%0d lit cycles: got %0d expected %0d", b, on_cycles, 2 * b * STEP);
            end
        end
        $display("test_brightness done");
    endtask

    task automatic test_enable_mask();
        digit_en = 4'b0101; brightness = 2'd3; blank = 1'b0;
        do_reset();
        for (int i = 0; i < 4 * DIV + 5; i++) step("mask_0101");
        digit_en = 4'b1000;
        for (int i = 0; i < 3 * DIV; i++) step("mask_1000");
        n_cmp++;
        if (seg_sel !== 2'd3 || anodes !== 4'b0111) begin
            n_bad++;
            $display("FAIL mask_settle: got %0d/%b expected 3/0111", seg_sel, anodes);
        end
        $display("test_enable_mask done");
    endtask

    task automatic test_all_disabled();
        int ticks;
        digit_en = 4'b0000; brightness = 2'd3; blank = 1'b0;
        ticks = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            step("all_disabled");
            if (slot_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks != 3) begin
            n_bad++;
            $display("FAIL disabled_ticks: got %0d expected 3", ticks);
        end
        $display("test_all_disabled done");
    endtask

    task automatic test_blank();
        digit_en = 4'b1111; brightness = 2'd3; blank = 1'b0;
        do_reset();
        for (int i = 0; i < DIV + 5; i++) step("blank_pre");
        blank = 1'b1;
        for (int i = 0; i < 5; i++) step("blank_on");
        blank = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) step("blank_post");
        $display("test_blank done");
    endtask

    task automatic test_mid_reset();
        digit_en = 4'b1111; brightness = 2'd3; blank = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * DIV + 7; i++) step("midreset_pre");
        do_reset();
        for (int i = 0; i < DIV + 2; i++) step("midreset_post");
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        digit_en = 4'($urandom); brightness = 2'($urandom); blank = 1'b0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0)  digit_en   = 4'($urandom);
            if ($urandom_range(0, 9) == 0)  brightness = 2'($urandom);
            if ($urandom_range(0, 15) == 0) blank      = ~blank;
            reset = ($urandom_range(0, 149) == 0);
            step("random");
        end
        reset = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1; digit_en = '0; brightness = '0; blank = 1'b0;
        m_cnt = 0; m_idx = 0;
        exp_anodes = '1; exp_sel = '0; exp_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_brightness();
        test_enable_mask();
        test_all_disabled();
        test_blank();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
